// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_cntr,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_cntr,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_z,
    output logic             rsp0_o,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_z,
    output logic             rsp1_o,
    output logic             rsp1_err,
    output logic [3:0]       alu_cntr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_o,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, last_q, last_d, ill_q, ill_d;
    logic z_q, z_d, o_q, o_d, err_q, err_d;
    logic [3:0] cntr_q, cntr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic gnt1, take, exec_ok;
    // Grant selection, handshake outputs and ALU drive; illegal ops run a harmless add of zeros
    always_comb begin
        gnt1        = req1_valid && (!req0_valid || !last_q);
        take        = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready  = take && !gnt1;
        req1_ready  = take && gnt1;
        exec_ok     = (state_q == EXEC) && !ill_q;
        alu_cntr    = exec_ok ? cntr_q : 4'b1000;
        alu_a       = exec_ok ? a_q : '0;
        alu_b       = exec_ok ? b_q : '0;
        rsp0_valid  = (state_q == RESP) && !owner_q;
        rsp1_valid  = (state_q == RESP) && owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp0_z      = rsp0_valid && z_q;
        rsp0_o      = rsp0_valid && o_q;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp1_z      = rsp1_valid && z_q;
        rsp1_o      = rsp1_valid && o_q;
        rsp1_err    = rsp1_valid && err_q;
        busy        = state_q != IDLE;
    end
    // Next-state: latch the granted request, capture the ALU one cycle later, hold until accepted
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        ill_d    = ill_q;
        cntr_d   = cntr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        z_d      = z_q;
        o_d      = o_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (take) begin
                owner_d = gnt1;
                last_d  = gnt1;
                cntr_d  = gnt1 ? req1_cntr : req0_cntr;
                a_d     = gnt1 ? req1_a : req0_a;
                b_d     = gnt1 ? req1_b : req0_b;
                ill_d   = !cntr_d[3] && (cntr_d[2:0] != 3'b100);
                state_d = EXEC;
            end
            EXEC: begin
                result_d = ill_q ? '0 : alu_result;
                z_d      = !ill_q && alu_z;
                o_d      = !ill_q && alu_o;
                err_d    = ill_q;
                state_d  = RESP;
            end
            RESP: state_d = (owner_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // State registers; last grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            ill_q    <= 1'b0;
            cntr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            ill_q    <= ill_d;
            cntr_q   <= cntr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            z_q      <= z_d;
            o_q      <= o_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector and sequence bench for alu_share_arb with a stand-in ALU
module tb_alu_share_arb;
    logic clk = 1'b0, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_cntr, req1_cntr, alu_cntr;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic rsp0_valid, rsp0_ready, rsp0_z, rsp0_o, rsp0_err;
    logic rsp1_valid, rsp1_ready, rsp1_z, rsp1_o, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic alu_z, alu_o, busy;
    int n_chk = 0, n_fail = 0;

    alu_share_arb #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntr(req0_cntr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntr(req1_cntr), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_z(rsp0_z), .rsp0_o(rsp0_o), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_z(rsp1_z), .rsp1_o(rsp1_o), .rsp1_err(rsp1_err),
        .alu_cntr(alu_cntr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_z(alu_z), .alu_o(alu_o),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: o is the signed/unsigned less-than for the compare ops, signed overflow for add
    function automatic logic [33:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic o;
        o = 1'b0;
        case (c)
            4'b1000: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b1001: r = a & b;
            4'b1010: r = a ^ b;
            4'b1011: r = a | b;
            4'b1100: begin r = a - b; o = $signed(a) < $signed(b); end
            4'b0100: begin r = a - b; o = a < b; end
            4'b1101: r = a << b[4:0];
            4'b1110: r = a >> b[4:0];
            4'b1111: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'h0;
        endcase
        return {r == 32'h0, o, r};
    endfunction

    assign {alu_z, alu_o, alu_result} = alu_model(alu_cntr, alu_a, alu_b);

    typedef struct {
        logic        rid;
        logic [3:0]  cntr;
        logic [31:0] a, b, res;
        logic        z, o, err;
    } vec_t;
    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int g[$];
        vecs[0]  = '{1'b0, 4'b1000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1010, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1011, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1100, 32'd9,         32'd9,         32'h0,         1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0100, 32'd1,         32'hFFFF_FFFF, 32'd2,         1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b1101, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b1110, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0001, 32'd5,         32'd7,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'b0111, 32'd3,         32'd3,         32'h0,         1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 4'b1000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1, 1'b0};
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
        {req0_cntr, req1_cntr, req0_a, req0_b, req1_a, req1_b} = '0;
        do_reset();
        chk("reset busy", busy, 0);
        chk("reset rsp0_valid", rsp0_valid, 0);
        chk("reset rsp1_valid", rsp1_valid, 0);
        chk("reset rsp0_err", rsp0_err, 0);
        chk("reset ready", {req0_ready, req1_ready}, 0);
        chk("reset alu_cntr", alu_cntr, 4'b1000);

        // single-requester vectors; operands are scrambled right after the grant edge
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = vecs[i];
            if (!v.rid) begin req0_valid = 1; req0_cntr = v.cntr; req0_a = v.a; req0_b = v.b; end
            else        begin req1_valid = 1; req1_cntr = v.cntr; req1_a = v.a; req1_b = v.b; end
            #1;
            chk($sformatf("v%0d ready", i), {req1_ready, req0_ready}, v.rid ? 2 : 1);
            tick();
            {req0_valid, req1_valid} = '0;
            req0_a = ~v.a; req0_b = ~v.b; req1_a = ~v.a; req1_b = ~v.b; req0_cntr = 4'b1011; req1_cntr = 4'b1011;
            #1;
            chk($sformatf("v%0d exec busy", i), busy, 1);
            chk($sformatf("v%0d exec alu_cntr", i), alu_cntr, v.err ? 4'b1000 : v.cntr);
            chk($sformatf("v%0d exec alu_a", i), alu_a, v.err ? 0 : v.a);
            chk($sformatf("v%0d exec rsp_valid", i), {rsp1_valid, rsp0_valid}, 0);
            tick();
            chk($sformatf("v%0d rsp_valid", i), {rsp1_valid, rsp0_valid}, v.rid ? 2 : 1);
            chk($sformatf("v%0d result", i), v.rid ? rsp1_result : rsp0_result, v.res);
            chk($sformatf("v%0d zoe", i), v.rid ? {rsp1_z, rsp1_o, rsp1_err} : {rsp0_z, rsp0_o, rsp0_err}, {v.z, v.o, v.err});
            chk($sformatf("v%0d other result", i), v.rid ? rsp0_result : rsp1_result, 0);
            if (!v.rid) rsp0_ready = 1; else rsp1_ready = 1;
            tick();
            {rsp0_ready, rsp1_ready} = '0;
            chk($sformatf("v%0d done busy", i), busy, 0);
            chk($sformatf("v%0d done valid", i), {rsp1_valid, rsp0_valid}, 0);
            chk($sformatf("v%0d done result", i), v.rid ? rsp1_result : rsp0_result, 0);
        end

        // fairness under continuous requests from both
        do_reset();
        req0_valid = 1; req0_cntr = 4'b1100; req0_a = 32'hFFFF_FFFD; req0_b = 32'd2;
        req1_valid = 1; req1_cntr = 4'b0100; req1_a = 32'd1;         req1_b = 32'hFFFF_FFFF;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req0_ready && req1_ready) chk("fair both ready", 1, 0);
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (rsp0_valid) begin
                chk("fair rsp0 result", rsp0_result, 32'hFFFF_FFFB);
                chk("fair rsp0 o", rsp0_o, 1);
            end
            if (rsp1_valid) begin
                chk("fair rsp1 result", rsp1_result, 32'd2);
                chk("fair rsp1 o", rsp1_o, 1);
            end
            tick();
        end
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
        chk("fair grant count", g.size(), 4);
        for (int k = 0; k < 4 && k < g.size(); k++) chk($sformatf("fair grant %0d", k), g[k], k % 2);
        tick();

        // backpressure on requester 1 while requester 0 waits
        req1_valid = 1; req1_cntr = 4'b1100; req1_a = 32'd9; req1_b = 32'd9;
        #1;
        chk("bp req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_cntr = 4'b1000; req0_a = 32'd1; req0_b = 32'd1;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp rsp1_valid", rsp1_valid, 1);
            chk("bp rsp1_result", rsp1_result, 0);
            chk("bp rsp1_z", rsp1_z, 1);
            chk("bp busy", busy, 1);
            chk("bp req0_ready", req0_ready, 0);
            tick();
        end
        rsp1_ready = 1;
        #1;
        chk("bp still valid", rsp1_valid, 1);
        tick();
        rsp1_ready = 0;
        chk("bp idle busy", busy, 0);
        chk("bp idle rsp1_valid", rsp1_valid, 0);
        chk("bp req0 granted", req0_ready, 1);
        req0_valid = 0;
        tick();
        chk("drop no grant", busy, 0);

        // reset in EXEC (requester 1), then in RESP (requester 0)
        req1_valid = 1; req1_cntr = 4'b1000; req1_a = 32'd2; req1_b = 32'd3;
        tick();
        req1_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst exec busy", busy, 0);
        chk("rst exec valid", {rsp1_valid, rsp0_valid}, 0);
        tick();
        chk("rst exec stays idle", {busy, rsp1_valid}, 0);
        req0_valid = 1; req0_cntr = 4'b1000; req0_a = 32'd4; req0_b = 32'd4;
        tick();
        req0_valid = 0;
        tick();
        chk("rst resp pre valid", rsp0_valid, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst resp busy", busy, 0);
        chk("rst resp valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst resp result", rsp0_result, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst tie grant", {req1_ready, req0_ready}, 2'b01);
        {req0_valid, req1_valid} = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. the execute stage (port 0) and the branch-compare/address path (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. The block registers operands, drives the ALU for one cycle, then captures and holds the result plus flags until the owning requester accepts it.
- Rejects ALU control codes the ALU does not define.

Parameters:
- WIDTH, 32, operand/result width; must match the shared ALU.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_cntr  in  4  ALU control code for requester 0
- req0_a, req0_b  in  WIDTH  operands for requester 0
- req1_valid, req1_ready, req1_cntr, req1_a, req1_b  same, requester 1
- rsp0_valid  out  1  response for requester 0 available
- rsp0_ready  in  1  requester 0 takes response
- rsp0_result  out  WIDTH  captured alu_result
- rsp0_z, rsp0_o  out  1  captured z_flag / o_flag
- rsp0_err  out  1  operation rejected as illegal code
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_z, rsp1_o, rsp1_err  same, requester 1
- alu_cntr  out  4  to shared ALU
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_result  in  WIDTH  from shared ALU
- alu_z, alu_o  in  1  from shared ALU z_flag / o_flag
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Legal ALU codes:
  - 4'b1000 add, 1001 and, 1010 xor, 1011 or, 1100 sub/slt (signed), 1101 sll, 1110 srl, 1111 sra.
  - 4'b0100 unsigned sub/sltu.
  - All other codes with cntr[3]=0 are illegal.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, for the granted requester only; at most one ready high per cycle.
  - Grant: if exactly one valid, grant it. If both valid, grant the one not in last_grant.
  - On grant edge: latch cntr, a, b and owner id; set illegal flag = (cntr[3]==0 && cntr[2:0]!=3'b100); last_grant <= owner; go EXEC.
  - No valid: stay IDLE.
- EXEC (exactly one cycle):
  - alu_cntr/alu_a/alu_b = latched values. If the illegal flag is set, drive 4'b1000 with a=b=0 instead.
  - At the edge: result_q <= illegal ? 0 : alu_result; z_q <= illegal ? 0 : alu_z; o_q <= illegal ? 0 : alu_o; err_q <= illegal; go RESP.
- RESP:
  - rsp<owner>_valid=1; other rsp valid=0.
  - Held stable until rsp<owner>_ready sampled high, then go IDLE.
  - rspN_ready while rspN_valid=0 is ignored.
- Outside EXEC: alu_cntr=4'b1000, alu_a=alu_b=0.
- rspN_result/z/o/err show the captured registers whenever valid, and 0 otherwise.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid high in cycle T+2.
  - Minimum 3 cycles per operation (accept, exec, response handshake).
  - A new request is not accepted in the RESP cycle.
- Reset (rst_n=0 at an edge):
  - State -> IDLE; last_grant -> 1, so requester 0 wins the first tie.
  - All captured registers -> 0; all ready/valid/err outputs 0; busy 0.
  - Any in-flight operation or unaccepted response is discarded.
  - Applies mid-EXEC or mid-RESP identically.
- Requester valid dropping before grant: no grant, no effect.
- Operands are sampled only at the grant edge; later changes are ignored.
- Fairness: under continuous requests from both, grants strictly alternate, 0,1,0,1…

Test Plan:
- Reset then req0 {cntr=4'b1000, a=5, b=7} alone -> req0_ready=1 at T; rsp0_valid at T+2, result=12, z=0, err=0; rsp1_valid stays 0.
- Both valid continuously: req0 {1100, a=-3, b=2}, req1 {0100, a=1, b=32'hFFFF_FFFF}, rsp readies held 1:
  - grant order 0,1,0.
  - rsp0 result=-5, o=1.
  - rsp1 result=2, o=1.
- req1 {1100, a=9, b=9} with rsp1_ready held 0 for 5 cycles -> rsp1_valid held, result=0, z=1 stable; busy=1; req0_ready stays 0 throughout; IDLE on the cycle after rsp1_ready=1.
- req0 illegal code 4'b0001 -> rsp0_err=1, result=0, z=0, o=0; alu_cntr=4'b1000 during EXEC.
- rst_n=0 for one edge during EXEC, then during RESP -> rsp valids 0 and busy 0 after the edge; next tie grants requester 0.
- req0 {1111, a=32'h8000_0000, b=4} -> result 32'hF800_0000; operands changed after grant do not alter the result.
